// File: rtl/selector_driver.sv
// Sweeps a one-hot select across four selector inputs, holding each code SETTLE cycles
// and capturing s0 on the last cycle of each hold window into a four-slot readback file.
module selector_driver #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic [2:0] op_in,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [2:0] opCodeA,
  output logic [3:0] select,
  input  logic [7:0] s0,
  output logic       busy,
  output logic       done,
  output logic [3:0] res_valid,
  input  logic [1:0] rd_idx,
  output logic [7:0] rd_data
);
  // state | meaning
  // IDLE  | select parked at 0000, waiting for start
  // HOLD  | one-hot code driven, counting the settle window
  // DONE  | one-cycle completion pulse, start ignored
  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [3:0] sel_q, sel_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] res_q [4];
  logic [7:0] res_d [4];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          op_d    = op_in;
          sel_d   = 4'b0001;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          valid_d = 4'b0000;
          busy_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 4'd1;
        // s0 has settled for the whole window by its last cycle
        if (cnt_q == LAST_CNT) begin
          res_d[idx_q]   = s0;
          valid_d[idx_q] = 1'b1;
          if (idx_q != 2'd3) begin
            sel_d = sel_q << 1;
            idx_d = idx_q + 2'd1;
            cnt_d = 4'd0;
          end else begin
            sel_d   = 4'b0000;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '{default: 8'h00};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign opCodeA   = op_q;
  assign select    = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign res_valid = valid_q;
  assign rd_data   = res_q[rd_idx];

endmodule
